// File: rtl/uart_start_detect.sv
// UART RX start-bit detector: 2-FF synchroniser, falling-edge detect,
// prescale-clamped mid-bit majority vote and saturating glitch counter.
module uart_start_detect #(
    parameter int PRESCALE_WIDTH   = 6,
    parameter int VOTE_SAMPLES     = 3,
    parameter int GLITCH_CNT_WIDTH = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        rx_in,
    input  logic                        det_en,
    input  logic [PRESCALE_WIDTH-1:0]   prescale,
    input  logic                        glitch_clr,
    output logic                        strt_valid,
    output logic                        strt_glitch,
    output logic                        busy,
    output logic [PRESCALE_WIDTH-1:0]   edge_cnt,
    output logic [GLITCH_CNT_WIDTH-1:0] glitch_cnt
);

    localparam int PW = PRESCALE_WIDTH;
    localparam int GW = GLITCH_CNT_WIDTH;
    localparam logic [PW-1:0] P_MIN = PW'(2 * VOTE_SAMPLES);
    localparam logic [PW-1:0] HALF  = PW'(VOTE_SAMPLES / 2);
    localparam logic [2:0]    HALF3 = 3'(VOTE_SAMPLES / 2);

    typedef enum logic [1:0] {IDLE, CHECK, HOLD} state_t;

    state_t        state, state_nxt;
    logic          rx_meta, rx_s, rx_prev, fall;
    logic [PW-1:0] p_lat, p_nxt, p_eff, edge_nxt;
    logic [PW-1:0] ctr, lo, hi;
    logic [2:0]    ones, ones_nxt, ones_acc;
    logic          sample, last, valid_nxt, glitch_nxt;
    logic [GW-1:0] gcnt_nxt;

    // Idle-high reset on the whole line path avoids a false edge on release.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall     = rx_prev & ~rx_s;
    assign p_eff    = (prescale < P_MIN) ? P_MIN : prescale;
    assign ctr      = p_lat >> 1;
    assign lo       = ctr - HALF;
    assign hi       = ctr + HALF;
    assign sample   = (edge_cnt >= lo) && (edge_cnt <= hi);
    assign ones_acc = ones + 3'(sample & rx_s);
    assign last     = (edge_cnt == p_lat - PW'(1));
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        p_nxt      = p_lat;
        edge_nxt   = '0;
        ones_nxt   = ones;
        valid_nxt  = 1'b0;
        glitch_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (det_en && fall) begin
                    state_nxt = CHECK;
                    p_nxt     = p_eff;
                    ones_nxt  = '0;
                end
            end
            CHECK: begin
                if (!det_en) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    // Final vote includes this cycle's sample.
                    if (ones_acc <= HALF3) begin
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        glitch_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end
                end else begin
                    edge_nxt = edge_cnt + PW'(1);
                    ones_nxt = ones_acc;
                end
            end
            HOLD: begin
                if (!det_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        gcnt_nxt = glitch_cnt;
        if (glitch_clr)
            gcnt_nxt = '0;
        else if (glitch_nxt && !(&glitch_cnt))
            gcnt_nxt = glitch_cnt + GW'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            p_lat       <= P_MIN;
            edge_cnt    <= '0;
            ones        <= '0;
            strt_valid  <= 1'b0;
            strt_glitch <= 1'b0;
            glitch_cnt  <= '0;
        end else begin
            state       <= state_nxt;
            p_lat       <= p_nxt;
            edge_cnt    <= edge_nxt;
            ones        <= ones_nxt;
            strt_valid  <= valid_nxt;
            strt_glitch <= glitch_nxt;
            glitch_cnt  <= gcnt_nxt;
        end
    end

endmodule

// File: tb/tb_uart_start_detect.sv
// Bench for uart_start_detect: frame table with scoreboarded pulses,
// plus abort, saturation, clear and mid-CHECK reset sequences.
module tb_uart_start_detect;

    logic       CLK = 1'b0;
    logic       RST;
    logic       rx_in;
    logic       det_en;
    logic [5:0] prescale;
    logic       glitch_clr;
    logic       strt_valid;
    logic       strt_glitch;
    logic       busy;
    logic [5:0] edge_cnt;
    logic [7:0] glitch_cnt;

    uart_start_detect dut (
        .CLK         (CLK),
        .RST         (RST),
        .rx_in       (rx_in),
        .det_en      (det_en),
        .prescale    (prescale),
        .glitch_clr  (glitch_clr),
        .strt_valid  (strt_valid),
        .strt_glitch (strt_glitch),
        .busy        (busy),
        .edge_cnt    (edge_cnt),
        .glitch_cnt  (glitch_cnt)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int exp_gc = 0;

    typedef struct {
        logic kind;
        int   at;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [5:0]  pre;
        logic [5:0]  pre_mid;
        logic [63:0] pat;
        logic        clr;
        logic        exp_valid;
        int          exp_p;
    } frame_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cyc %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Pulse monitor: each pulse must match the oldest expected entry.
    always @(negedge CLK) begin
        exp_t e;
        if (RST && (strt_valid || strt_glitch)) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: valid=%0b glitch=%0b cyc=%0d want none",
                         strt_valid, strt_glitch, cyc);
            end else begin
                e = sbq.pop_front();
                if (strt_valid !== e.kind || strt_glitch !== ~e.kind
                    || cyc != e.at) begin
                    bad++;
                    $display("FAIL pulse: valid=%0b glitch=%0b cyc=%0d want valid=%0b cyc=%0d",
                             strt_valid, strt_glitch, cyc, e.kind, e.at);
                end
            end
        end
    end

    // Index i of pat is the rx_in level driven i cycles after the fall.
    task automatic run_frame(input frame_t f);
        int n;
        int pe;
        pe = f.exp_p;
        @(negedge CLK);
        prescale = f.pre;
        det_en   = 1'b1;
        rx_in    = f.pat[0];
        n        = cyc;
        sbq.push_back('{kind: f.exp_valid, at: n + pe + 3});
        for (int i = 1; i <= pe + 1; i++) begin
            @(negedge CLK);
            if (i == 5 && f.pre_mid != 0) prescale = f.pre_mid;
            rx_in = f.pat[i];
            chk("edge_cnt", edge_cnt, (i >= 3) ? i - 3 : 0);
            chk("busy_chk", busy, i >= 3);
        end
        @(negedge CLK);
        chk("edge_last", edge_cnt, pe - 1);
        rx_in      = 1'b1;
        glitch_clr = f.clr;
        @(negedge CLK);
        glitch_clr = 1'b0;
        if (f.clr) exp_gc = 0;
        else if (!f.exp_valid && exp_gc < 255) exp_gc++;
        chk("glitch_cnt", glitch_cnt, exp_gc);
        chk("busy_after", busy, f.exp_valid);
        @(negedge CLK);
        chk("sb_drained", sbq.size(), 0);
        chk("busy_hold", busy, f.exp_valid);
        chk("edge_zero", edge_cnt, 0);
        if (f.exp_valid) begin
            det_en = 1'b0;
            @(negedge CLK);
            chk("hold_exit", busy, 0);
            det_en = 1'b1;
        end
        repeat (3) @(negedge CLK);
    endtask

    frame_t tbl[12];
    frame_t gl;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0]  = '{6'd8,  6'd0,  64'hFFFF_FFFF_FFFF_FF00, 1'b0, 1'b1, 8};
        tbl[1]  = '{6'd16, 6'd0,  64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 16};
        tbl[2]  = '{6'd8,  6'd0,  64'h20,  1'b0, 1'b1, 8};
        tbl[3]  = '{6'd8,  6'd0,  64'h60,  1'b0, 1'b0, 8};
        tbl[4]  = '{6'd3,  6'd0,  64'h0,   1'b0, 1'b1, 6};
        tbl[5]  = '{6'd3,  6'd0,  64'h18,  1'b0, 1'b0, 6};
        tbl[6]  = '{6'd16, 6'd0,  64'h300, 1'b0, 1'b0, 16};
        tbl[7]  = '{6'd16, 6'd0,  64'h180, 1'b0, 1'b1, 16};
        tbl[8]  = '{6'd16, 6'd0,  64'hC00, 1'b0, 1'b1, 16};
        tbl[9]  = '{6'd32, 6'd0,  64'h0,   1'b0, 1'b1, 32};
        tbl[10] = '{6'd7,  6'd0,  64'h30,  1'b0, 1'b0, 7};
        tbl[11] = '{6'd8,  6'd32, 64'h0,   1'b0, 1'b1, 8};
        gl      = '{6'd6,  6'd0,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 6};

        RST = 1'b0;
        rx_in = 1'b1;
        det_en = 1'b1;
        prescale = 6'd8;
        glitch_clr = 1'b0;
        #1;
        chk("rst_outputs", {strt_valid, strt_glitch, busy, edge_cnt, glitch_cnt}, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (50) begin
            @(negedge CLK);
            chk("post_reset_idle",
                {strt_valid, strt_glitch, busy, edge_cnt, glitch_cnt}, 0);
        end

        for (int k = 0; k < 12; k++) run_frame(tbl[k]);

        for (int k = 0; k < 260; k++) run_frame(gl);
        chk("glitch_sat", glitch_cnt, 255);

        gl.clr = 1'b1;
        run_frame(gl);
        gl.clr = 1'b0;
        run_frame(gl);
        chk("glitch_after_clr", glitch_cnt, 1);

        @(negedge CLK);
        glitch_clr = 1'b1;
        @(negedge CLK);
        glitch_clr = 1'b0;
        exp_gc = 0;
        chk("idle_clr", glitch_cnt, 0);

        // Abort: det_en drops while edge_cnt is 2.
        @(negedge CLK);
        prescale = 6'd8;
        rx_in = 1'b0;
        n = cyc;
        for (int i = 1; i <= 5; i++) @(negedge CLK);
        chk("abort_edge", edge_cnt, 2);
        det_en = 1'b0;
        @(negedge CLK);
        chk("abort_busy", busy, 0);
        chk("abort_edge0", edge_cnt, 0);
        rx_in = 1'b1;
        repeat (14) @(negedge CLK);
        chk("abort_gc", glitch_cnt, exp_gc);
        chk("abort_time", cyc - n, 20);
        det_en = 1'b1;
        repeat (3) @(negedge CLK);

        // Reset mid-CHECK: nothing may follow release.
        run_frame(gl);
        @(negedge CLK);
        rx_in = 1'b0;
        repeat (6) @(negedge CLK);
        chk("pre_rst_edge", edge_cnt, 3);
        RST = 1'b0;
        #1;
        chk("midrst_outputs",
            {strt_valid, strt_glitch, busy, edge_cnt, glitch_cnt}, 0);
        exp_gc = 0;
        rx_in = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (15) @(negedge CLK);
        chk("midrst_after",
            {strt_valid, strt_glitch, busy, edge_cnt, glitch_cnt}, 0);

        run_frame(tbl[0]);
        chk("final_sb", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
